apb_clk_cfg_if: RTL
===================

# apb_clk_cfg_if

APB slave that translates processor register accesses into the three clock-generator configuration channels (soc, per, cluster) of `clk_gen`. It sits directly upstream of `clk_gen` on the SoC peripheral bus: it issues one `*_cfg_req` / `*_cfg_ack` transaction per APB access. It also exposes the synchronized `*_cfg_lock` status as a local register, and bounds every transaction with a timeout so a silent generator cannot hang the bus.

## Interface
Parameters:
- `APB_ADDR_WIDTH`, 12, width of `paddr_i`.
- `TIMEOUT_CYCLES`, 255, maximum cycles spent waiting for ack (1..1023).
- `SYNC_STAGES`, 2, flops in each lock synchronizer (≥2).

Ports:
- `clk_i`  in  1  single clock; all logic on rising edge.
- `rstn_i`  in  1  reset; **synchronous, active-low**.
- `paddr_i`  in  APB_ADDR_WIDTH  APB address.
- `pwdata_i`  in  32  APB write data.
- `pwrite_i`, `psel_i`, `penable_i`  in  1 each  APB controls.
- `prdata_o`  out  32  APB read data.
- `pready_o`, `pslverr_o`  out  1 each  APB response.
- `{soc,per,cluster}_cfg_req_o`  out  1  request to clk_gen channel.
- `{soc,per,cluster}_cfg_add_o`  out  5  channel register address.
- `{soc,per,cluster}_cfg_data_o`  out  32  write data.
- `{soc,per,cluster}_cfg_wrn_o`  out  1  1 = write, 0 = read.
- `{soc,per,cluster}_cfg_ack_i`  in  1  ack from clk_gen.
- `{soc,per,cluster}_cfg_r_data_i`  in  32  read data from clk_gen.
- `{soc,per,cluster}_cfg_lock_i`  in  1  async PLL lock.

## Operation
Address decode:
- `paddr_i[8:7]` selects the channel: 0 = soc, 1 = per, 2 = cluster, 3 = local.
- `paddr_i[6:2]` is the 5-bit cfg address.
- `paddr_i[1:0]` and bits above 8 are ignored.

Local space (channel 3):
- Offset 0 is STATUS, read-only: `{29'b0, cluster_lock_s, per_lock_s, soc_lock_s}`.
- Any write to channel 3, or any access to another local offset, gives PSLVERR=1 and PRDATA=0.

FSM states: IDLE, REQ, RESP.
- IDLE:
  - On `psel_i & penable_i` with channel 0..2, latch channel, add, pwdata and `wrn = pwrite_i`, then go to REQ.
  - On channel 3, load the local result and go to RESP.
- REQ:
  - The selected `*_cfg_req_o` is 1. Add/data/wrn are held stable from the latched values.
  - When the selected ack is 1: capture `r_data` (reads) or 0 (writes), set err=0, go to RESP.
  - When the timeout counter reaches TIMEOUT_CYCLES−1 with no ack: set err=1, prdata=0, go to RESP.
- RESP: `pready_o`=1 for exactly one cycle with the captured prdata/pslverr, then go to IDLE.

Non-selected channels:
- req=0.
- add/data/wrn hold their last values. They are not X; reset value is 0.

Locks: each lock passes through a SYNC_STAGES flop chain before use in STATUS. Locks do not gate requests.

## Timing
Reset values (all outputs 0):
- `pready_o`, `pslverr_o`, `prdata_o`, all `req`, all `add`/`data`/`wrn`.
- FSM = IDLE, timeout counter = 0, synchronizer flops = 0.

Latency:
- Channel access with same-cycle ack: the access phase lasts 3 cycles (IDLE → REQ → RESP).
- Ack arriving k cycles into REQ gives 3+k cycles.
- Local access: 2 cycles.
- Timeout: `pready_o` asserts TIMEOUT_CYCLES+2 cycles after the access phase starts.

Handshake:
- `req` rises the cycle after the access phase is seen.
- `req` falls the cycle after ack is sampled; it is 1 for at least one cycle.
- The block never issues a back-to-back req without passing through IDLE.

Boundary conditions:
- Acks on non-selected channels are ignored.
- Ack in the same cycle as timeout expiry: ack wins, err=0.
- Ack arriving after timeout is ignored.
- Lock change is visible in STATUS SYNC_STAGES+1 cycles after the input edge.
- `psel_i` dropping mid-transfer (protocol violation): the cfg handshake still completes and RESP is still issued for one cycle.
- Reset asserted in any state: the next edge forces all reset values, including dropping `req`.

## Structure
Package `clk_cfg_pkg` holds:
- `clk_cfg_ch_e` enum {CH_SOC, CH_PER, CH_CLUSTER, CH_LOCAL}.
- `clk_cfg_state_e` enum {IDLE, REQ, RESP}.
- localparams CH_MSB=8, CH_LSB=7, ADD_MSB=6, ADD_LSB=2, STATUS_OFFS=5'd0.

Sub-module `clk_cfg_lock_sync`: parameterized flop-chain synchronizer, instantiated three times.

## Test plan
- Reset: hold `rstn_i`=0 for 5 cycles with `psel_i`=1 → all outputs 0 and no req.
- Read per add 1 with a same-cycle-ack model (model returns 0x00020002) → PRDATA=0x00020002, PSLVERR=0, pready on the 3rd access cycle, `per_cfg_wrn_o`=0.
- Write soc add 3 data 0xA5A5_0F0F, ack delayed 4 cycles → `soc_cfg_data_o`=0xA5A50F0F, `add`=3, `wrn`=1 held stable for all 5 req cycles; pready on cycle 7.
- Cluster ack tied 0, TIMEOUT_CYCLES=8 → pready on cycle 10 with PSLVERR=1, PRDATA=0; the next access succeeds normally.
- Locks soc=1, per=0, cluster=1 → read of 0x180 returns 0x5 after the sync delay; write to 0x180 → PSLVERR=1.
- Reset asserted while in REQ → `req` is 0 on the next edge; after release, the next read completes correctly.

Source files
------------

// File: rtl/clk_cfg_pkg.sv
// Shared types and constants for the APB-to-clk_gen configuration bridge.
package clk_cfg_pkg;

  typedef enum logic [1:0] {
    CH_SOC     = 2'd0,
    CH_PER     = 2'd1,
    CH_CLUSTER = 2'd2,
    CH_LOCAL   = 2'd3
  } clk_cfg_ch_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } clk_cfg_state_e;

  localparam int unsigned CH_MSB  = 8;
  localparam int unsigned CH_LSB  = 7;
  localparam int unsigned ADD_MSB = 6;
  localparam int unsigned ADD_LSB = 2;
  localparam logic [4:0]  STATUS_OFFS = 5'd0;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned ADD_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 10;

  // Command presented on one clk_gen cfg channel.
  typedef struct packed {
    logic [ADD_W-1:0]  add;
    logic [DATA_W-1:0] data;
    logic              wrn;
  } clk_cfg_cmd_t;

endpackage

// File: rtl/clk_cfg_lock_sync.sv
// Flop-chain synchronizer bringing an asynchronous PLL lock into clk_i.
module clk_cfg_lock_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] r_chain;

  // Shift the async level through the chain; clear on reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) r_chain <= '0;
    else         r_chain <= {r_chain[STAGES-2:0], async_i};
  end

  assign sync_o = r_chain[STAGES-1];

endmodule

// File: rtl/apb_clk_cfg_if.sv
// APB slave bridging register accesses onto the soc/per/cluster clk_gen cfg
// channels, with a local STATUS register and an ack timeout.
module apb_clk_cfg_if
  import clk_cfg_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [31:0]               pwdata_i,
  input  logic                      pwrite_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic                      soc_cfg_req_o,
  output logic [4:0]                soc_cfg_add_o,
  output logic [31:0]               soc_cfg_data_o,
  output logic                      soc_cfg_wrn_o,
  input  logic                      soc_cfg_ack_i,
  input  logic [31:0]               soc_cfg_r_data_i,
  input  logic                      soc_cfg_lock_i,
  output logic                      per_cfg_req_o,
  output logic [4:0]                per_cfg_add_o,
  output logic [31:0]               per_cfg_data_o,
  output logic                      per_cfg_wrn_o,
  input  logic                      per_cfg_ack_i,
  input  logic [31:0]               per_cfg_r_data_i,
  input  logic                      per_cfg_lock_i,
  output logic                      cluster_cfg_req_o,
  output logic [4:0]                cluster_cfg_add_o,
  output logic [31:0]               cluster_cfg_data_o,
  output logic                      cluster_cfg_wrn_o,
  input  logic                      cluster_cfg_ack_i,
  input  logic [31:0]               cluster_cfg_r_data_i,
  input  logic                      cluster_cfg_lock_i
);

  clk_cfg_state_e    r_state, w_state_nxt;
  clk_cfg_ch_e       r_ch, w_ch_nxt, w_ch_dec;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  clk_cfg_cmd_t      r_cmd [NUM_CH];
  clk_cfg_cmd_t      w_cmd_nxt [NUM_CH];
  logic [NUM_CH-1:0] r_req, w_req_nxt;
  logic [DATA_W-1:0] r_prdata, w_prdata_nxt;
  logic              r_pslverr, w_pslverr_nxt;
  logic              r_pready, w_pready_nxt;

  logic [NUM_CH-1:0] w_lock_async, w_lock_s, w_ack_vec;
  logic [DATA_W-1:0] w_rdata_vec [NUM_CH];
  logic              w_ack_sel;
  logic [DATA_W-1:0] w_rdata_sel;
  logic [ADD_W-1:0]  w_add_dec;
  logic              w_unused_addr;

  assign w_ch_dec      = clk_cfg_ch_e'(paddr_i[CH_MSB:CH_LSB]);
  assign w_add_dec     = paddr_i[ADD_MSB:ADD_LSB];
  assign w_unused_addr = ^{paddr_i[1:0], paddr_i[APB_ADDR_WIDTH-1:CH_MSB+1]};

  assign w_lock_async   = {cluster_cfg_lock_i, per_cfg_lock_i, soc_cfg_lock_i};
  assign w_ack_vec      = {cluster_cfg_ack_i, per_cfg_ack_i, soc_cfg_ack_i};
  assign w_rdata_vec[0] = soc_cfg_r_data_i;
  assign w_rdata_vec[1] = per_cfg_r_data_i;
  assign w_rdata_vec[2] = cluster_cfg_r_data_i;

  // One synchronizer per PLL lock feeding the STATUS register.
  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_lock
    clk_cfg_lock_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .async_i (w_lock_async[g]),
      .sync_o  (w_lock_s[g])
    );
  end

  // Pick ack and read data of the latched channel; others are ignored.
  always_comb begin
    w_ack_sel   = 1'b0;
    w_rdata_sel = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (r_ch == clk_cfg_ch_e'(2'(i))) begin
        w_ack_sel   = w_ack_vec[i];
        w_rdata_sel = w_rdata_vec[i];
      end
    end
  end

  // Next-state logic: decode, handshake, timeout and response capture.
  always_comb begin
    w_state_nxt   = r_state;
    w_ch_nxt      = r_ch;
    w_cnt_nxt     = r_cnt;
    w_cmd_nxt     = r_cmd;
    w_prdata_nxt  = r_prdata;
    w_pslverr_nxt = r_pslverr;
    w_req_nxt     = '0;
    w_pready_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (psel_i && penable_i) begin
          if (w_ch_dec == CH_LOCAL) begin
            w_state_nxt = RESP;
            if (!pwrite_i && (w_add_dec == STATUS_OFFS)) begin
              w_prdata_nxt  = DATA_W'(w_lock_s);
              w_pslverr_nxt = 1'b0;
            end else begin
              w_prdata_nxt  = '0;
              w_pslverr_nxt = 1'b1;
            end
          end else begin
            w_state_nxt = REQ;
            w_ch_nxt    = w_ch_dec;
            w_cnt_nxt   = '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
              if (w_ch_dec == clk_cfg_ch_e'(2'(i))) begin
                w_cmd_nxt[i] = '{add: w_add_dec, data: pwdata_i, wrn: pwrite_i};
              end
            end
          end
        end
      end
      REQ: begin
        if (w_ack_sel) begin
          w_state_nxt   = RESP;
          w_cnt_nxt     = '0;
          w_prdata_nxt  = r_cmd[r_ch[1:0]].wrn ? '0 : w_rdata_sel;
          w_pslverr_nxt = 1'b0;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt   = RESP;
          w_cnt_nxt     = '0;
          w_prdata_nxt  = '0;
          w_pslverr_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    for (int i = 0; i < int'(NUM_CH); i++) begin
      w_req_nxt[i] = (w_state_nxt == REQ) && (w_ch_nxt == clk_cfg_ch_e'(2'(i)));
    end
    w_pready_nxt = (w_state_nxt == RESP);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state   <= IDLE;
      r_ch      <= CH_SOC;
      r_cnt     <= '0;
      r_req     <= '0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
      r_pready  <= 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) r_cmd[i] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ch      <= w_ch_nxt;
      r_cnt     <= w_cnt_nxt;
      r_req     <= w_req_nxt;
      r_prdata  <= w_prdata_nxt;
      r_pslverr <= w_pslverr_nxt;
      r_pready  <= w_pready_nxt;
      r_cmd     <= w_cmd_nxt;
    end
  end

  assign prdata_o  = r_prdata;
  assign pready_o  = r_pready;
  assign pslverr_o = r_pslverr;

  assign soc_cfg_req_o      = r_req[0];
  assign soc_cfg_add_o      = r_cmd[0].add;
  assign soc_cfg_data_o     = r_cmd[0].data;
  assign soc_cfg_wrn_o      = r_cmd[0].wrn;
  assign per_cfg_req_o      = r_req[1];
  assign per_cfg_add_o      = r_cmd[1].add;
  assign per_cfg_data_o     = r_cmd[1].data;
  assign per_cfg_wrn_o      = r_cmd[1].wrn;
  assign cluster_cfg_req_o  = r_req[2];
  assign cluster_cfg_add_o  = r_cmd[2].add;
  assign cluster_cfg_data_o = r_cmd[2].data;
  assign cluster_cfg_wrn_o  = r_cmd[2].wrn;

endmodule
